fuzzifier_trap: RTL and testbench

- Registered three-set trapezoidal fuzzifier for one signed Q7.0 crisp input.
- Computes membership degrees for the NEG, ZERO and POS fuzzy sets, each a runtime-programmable trapezoid (a,b,c,d).
- Outputs are unsigned Q1.15 in [0, 0x7FFF].
- Sits between the input scaling stage and the rule/inference block of the fuzzy controller.

---
 rtl/fuzzy_pkg.sv | 17 +
 rtl/trap_mf.sv | 56 +++++
 rtl/fuzzifier_trap.sv | 71 +++++++
 tb/tb_fuzzifier_trap.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// Purpose: shared fixed-point types and membership constants for the fuzzy controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fuzzy_pkg;

   typedef logic signed [7:0] q7_0_t;
   typedef logic [15:0]       q1_15_t;

   localparam q1_15_t MU_ONE  = 16'h7FFF;
   localparam q1_15_t MU_ZERO = 16'h0000;

   // Clamp a raw 16-bit quotient into the legal Q1.15 membership range.
   function automatic q1_15_t mu_sat(input logic [15:0] raw);
      return (raw > MU_ONE) ? MU_ONE : raw;
   endfunction

endpackage

// File: rtl/trap_mf.sv
// Purpose: combinational trapezoidal membership function mu(x,a,b,c,d), Q7.0 in, Q1.15 out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluates continuously.
module trap_mf
   import fuzzy_pkg::*;
(
   input  logic signed [7:0] x,
   input  logic signed [7:0] a,
   input  logic signed [7:0] b,
   input  logic signed [7:0] c,
   input  logic signed [7:0] d,
   output logic [15:0]       mu
);

   logic [8:0]  num9;
   logic [8:0]  den9;
   logic [23:0] num;
   logic [23:0] den;
   logic [23:0] quo;
   logic [15:0] q16;
   logic        unused_quo_hi;

   // Upper quotient bits are discarded: the result is truncated to 16 bits before saturation.
   assign unused_quo_hi = ^quo[23:16];

   // Select the active segment in priority order, then share one divider for both slopes.
   always_comb begin
      mu   = MU_ZERO;
      num9 = '0;
      den9 = '0;
      num  = '0;
      den  = 24'd1;
      quo  = '0;
      q16  = '0;
      if (x <= a || x >= d) begin
         mu = MU_ZERO;
      end else if (x >= b && x <= c) begin
         mu = MU_ONE;
      end else begin
         if (x > a && x < b) begin
            num9 = {x[7], x} - {a[7], a};
            den9 = {b[7], b} - {a[7], a};
         end else begin
            num9 = {d[7], d} - {x[7], x};
            den9 = {d[7], d} - {c[7], c};
         end
         num = {15'd0, num9} << 15;
         // A zero-width slope cannot occur with the guards above, but keep the divider safe.
         den = (den9 == 9'd0) ? 24'd1 : {15'd0, den9};
         quo = num / den;
         q16 = quo[15:0];
         mu  = mu_sat(q16);
      end
   end

endmodule

// File: rtl/fuzzifier_trap.sv
// Purpose: registered three-set (NEG/ZERO/POS) trapezoidal fuzzifier for one Q7.0 input.
// Latency: 1 cycle from in_valid to out_valid; mu_* hold while in_valid is low.
// Backpressure: none; a new sample may be accepted every cycle.
module fuzzifier_trap
   import fuzzy_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic signed [7:0] x,
   input  logic signed [7:0] a_neg,
   input  logic signed [7:0] b_neg,
   input  logic signed [7:0] c_neg,
   input  logic signed [7:0] d_neg,
   input  logic signed [7:0] a_zero,
   input  logic signed [7:0] b_zero,
   input  logic signed [7:0] c_zero,
   input  logic signed [7:0] d_zero,
   input  logic signed [7:0] a_pos,
   input  logic signed [7:0] b_pos,
   input  logic signed [7:0] c_pos,
   input  logic signed [7:0] d_pos,
   output logic              out_valid,
   output logic [15:0]       mu_neg,
   output logic [15:0]       mu_zero,
   output logic [15:0]       mu_pos
);

   q1_15_t mu_neg_c, mu_zero_c, mu_pos_c;
   q1_15_t mu_neg_d, mu_zero_d, mu_pos_d;
   q1_15_t mu_neg_q, mu_zero_q, mu_pos_q;
   logic   out_valid_d, out_valid_q;

   trap_mf u_mf_neg  (.x(x), .a(a_neg),  .b(b_neg),  .c(c_neg),  .d(d_neg),  .mu(mu_neg_c));
   trap_mf u_mf_zero (.x(x), .a(a_zero), .b(b_zero), .c(c_zero), .d(d_zero), .mu(mu_zero_c));
   trap_mf u_mf_pos  (.x(x), .a(a_pos),  .b(b_pos),  .c(c_pos),  .d(d_pos),  .mu(mu_pos_c));

   // Load new memberships only on a valid sample; otherwise hold the last result.
   always_comb begin
      out_valid_d = in_valid;
      mu_neg_d    = mu_neg_q;
      mu_zero_d   = mu_zero_q;
      mu_pos_d    = mu_pos_q;
      if (in_valid) begin
         mu_neg_d  = mu_neg_c;
         mu_zero_d = mu_zero_c;
         mu_pos_d  = mu_pos_c;
      end
   end

   // Output registers with synchronous reset taking priority over in_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         mu_neg_q    <= MU_ZERO;
         mu_zero_q   <= MU_ZERO;
         mu_pos_q    <= MU_ZERO;
      end else begin
         out_valid_q <= out_valid_d;
         mu_neg_q    <= mu_neg_d;
         mu_zero_q   <= mu_zero_d;
         mu_pos_q    <= mu_pos_d;
      end
   end

   assign out_valid = out_valid_q;
   assign mu_neg    = mu_neg_q;
   assign mu_zero   = mu_zero_q;
   assign mu_pos    = mu_pos_q;

endmodule

// File: tb/tb_fuzzifier_trap.sv
// Purpose: self-checking bench for fuzzifier_trap with directed vectors and ordered random corners.
// Latency: expects results one clock after each in_valid sample.
// Backpressure: none exercised; the DUT has no ready.
module tb_fuzzifier_trap;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic signed [7:0] x;
   logic signed [7:0] a_neg, b_neg, c_neg, d_neg;
   logic signed [7:0] a_zero, b_zero, c_zero, d_zero;
   logic signed [7:0] a_pos, b_pos, c_pos, d_pos;
   logic              out_valid;
   logic [15:0]       mu_neg, mu_zero, mu_pos;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   fuzzifier_trap dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x),
      .a_neg(a_neg), .b_neg(b_neg), .c_neg(c_neg), .d_neg(d_neg),
      .a_zero(a_zero), .b_zero(b_zero), .c_zero(c_zero), .d_zero(d_zero),
      .a_pos(a_pos), .b_pos(b_pos), .c_pos(c_pos), .d_pos(d_pos),
      .out_valid(out_valid), .mu_neg(mu_neg), .mu_zero(mu_zero), .mu_pos(mu_pos)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one sample at a falling edge; outputs are observed at the next falling edge.
   task automatic step(input int xv, input logic v);
      x        = 8'(xv);
      in_valid = v;
      @(negedge clk);
   endtask

   task automatic set_defaults();
      a_neg  = -8'sd128; b_neg  = -8'sd64; c_neg  = -8'sd32; d_neg  = 8'sd0;
      a_zero = -8'sd16;  b_zero = 8'sd0;   c_zero = 8'sd0;   d_zero = 8'sd16;
      a_pos  = 8'sd0;    b_pos  = 8'sd32;  c_pos  = 8'sd64;  d_pos  = 8'sd127;
   endtask

   // Reference membership computed with plain integer arithmetic.
   function automatic logic [15:0] ref_mu(input int xv, input int a, input int b, input int c, input int d);
      int          num, den;
      logic [31:0] q;
      logic [15:0] q16;
      if (xv <= a || xv >= d) return 16'h0000;
      if (xv >= b && xv <= c) return 16'h7FFF;
      if (xv > a && xv < b) begin
         num = xv - a; den = b - a;
      end else begin
         num = d - xv; den = d - c;
      end
      if (den == 0) den = 1;
      q   = 32'((num * 32768) / den);
      q16 = q[15:0];
      return (q16 > 16'h7FFF) ? 16'h7FFF : q16;
   endfunction

   task automatic rand_corners(output int a, output int b, output int c, output int d);
      int v[4];
      int t;
      for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3 - i; j++)
            if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
      a = v[0]; b = v[1]; c = v[2]; d = v[3];
   endtask

   initial begin
      int an, bn, cn, dn, az, bz, cz, dz, ap, bp, cp, dp, xr;
      rst_n    = 1'b0;
      in_valid = 1'b1;
      x        = 8'sd0;
      set_defaults();

      // Reset dominates in_valid for two cycles.
      @(negedge clk);
      step(0, 1'b1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mu_neg",  {16'd0, mu_neg},  32'd0);
      chk("rst_mu_zero", {16'd0, mu_zero}, 32'd0);
      chk("rst_mu_pos",  {16'd0, mu_pos},  32'd0);

      rst_n = 1'b1;
      step(0, 1'b1);
      chk("x0_out_valid", {31'd0, out_valid}, 32'd1);
      chk("x0_mu_zero", {16'd0, mu_zero}, 32'h7FFF);
      chk("x0_mu_pos",  {16'd0, mu_pos},  32'd0);
      chk("x0_mu_neg",  {16'd0, mu_neg},  32'd0);

      step(-128, 1'b1); chk("xm128_mu_neg", {16'd0, mu_neg},  32'd0);
      step(-48, 1'b1);  chk("xm48_mu_neg",  {16'd0, mu_neg},  32'h7FFF);
      step(127, 1'b1);  chk("x127_mu_pos",  {16'd0, mu_pos},  32'd0);
      step(16, 1'b1);   chk("x16_mu_pos",   {16'd0, mu_pos},  32'd16384);
      step(96, 1'b1);   chk("x96_mu_pos",   {16'd0, mu_pos},  32'd16123);
      step(48, 1'b1);   chk("x48_mu_pos",   {16'd0, mu_pos},  32'h7FFF);

      // Handshake: one valid sample, then a changed x with in_valid low must not disturb mu.
      step(-8, 1'b1);
      chk("hs_mu_zero",   {16'd0, mu_zero}, 32'd16384);
      chk("hs_out_valid", {31'd0, out_valid}, 32'd1);
      step(8, 1'b0);
      chk("hs_hold_mu_zero", {16'd0, mu_zero}, 32'd16384);
      chk("hs_out_valid_drop", {31'd0, out_valid}, 32'd0);

      // Shifted NEG and ZERO sets.
      a_neg  = -8'sd100; b_neg  = -8'sd70; c_neg  = -8'sd50; d_neg  = -8'sd20;
      a_zero = -8'sd25;  b_zero = -8'sd5;  c_zero = -8'sd5;  d_zero = 8'sd25;
      step(-90, 1'b1); chk("sh_xm90_mu_neg", {16'd0, mu_neg}, 32'd10922);
      step(-60, 1'b1); chk("sh_xm60_mu_neg", {16'd0, mu_neg}, 32'h7FFF);
      step(-30, 1'b1); chk("sh_xm30_mu_neg", {16'd0, mu_neg}, 32'd10922);
      step(-5, 1'b1);  chk("sh_xm5_mu_zero", {16'd0, mu_zero}, 32'h7FFF);

      // Ordered random corners against the integer reference.
      for (int n = 0; n < 60; n++) begin
         rand_corners(an, bn, cn, dn);
         rand_corners(az, bz, cz, dz);
         rand_corners(ap, bp, cp, dp);
         a_neg  = 8'(an); b_neg  = 8'(bn); c_neg  = 8'(cn); d_neg  = 8'(dn);
         a_zero = 8'(az); b_zero = 8'(bz); c_zero = 8'(cz); d_zero = 8'(dz);
         a_pos  = 8'(ap); b_pos  = 8'(bp); c_pos  = 8'(cp); d_pos  = 8'(dp);
         xr = int'($urandom_range(0, 255)) - 128;
         step(xr, 1'b1);
         chk("rnd_mu_neg",  {16'd0, mu_neg},  {16'd0, ref_mu(xr, an, bn, cn, dn)});
         chk("rnd_mu_zero", {16'd0, mu_zero}, {16'd0, ref_mu(xr, az, bz, cz, dz)});
         chk("rnd_mu_pos",  {16'd0, mu_pos},  {16'd0, ref_mu(xr, ap, bp, cp, dp)});
      end

      in_valid = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
